// File: rtl/zap_irq_sync_arbiter.sv
// -----------------------------------------------------------------------------
// zap_irq_sync_arbiter
//
// Conditions N asynchronous interrupt lines into the core clock domain and
// presents one unmasked pending source at a time to the core through a
// request/acknowledge handshake.
//
// Each line has a two-flop synchroniser (meta -> sync_q), a one-cycle-delayed
// copy (sync_d) that is used for rising-edge detection, and a pending bit.
// Edge-mode lines latch pending on a synchronised rising edge. That pending bit
// is held until the core acknowledges that line. Level-mode lines simply follow
// the synchronised input.
//
// Optional build macro:
//   ZAP_IRQ_RR_EN  - defined: round-robin arbitration. The search starts at a
//                    pointer that advances past each acknowledged line.
//                    undefined: fixed priority, the lowest index wins, and no
//                    pointer flops exist.
//
// Ports:
//   i_clk       core clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_irq       [N]   asynchronous interrupt lines, active high
//   i_cfg_edge  [N]   per-line mode: 1 = rising-edge latched, 0 = level
//   i_mask      [N]   per-line mask: 1 = not eligible for arbitration
//   o_req       request to the core (registered)
//   o_id        [IDW] granted line index, valid while o_req = 1 (registered)
//   i_ack       core acknowledge, only honoured while o_req = 1
//   o_pending   [N]   raw pending vector before masking (registered)
//
// FSM states:
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no grant outstanding; grant the winner if any line eligible
//   S_REQ  | grant held (o_req = 1, o_id frozen) until i_ack
// -----------------------------------------------------------------------------
module zap_irq_sync_arbiter #(
    parameter  int N   = 8,
    localparam int IDW = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [N-1:0]   i_irq,
    input  logic [N-1:0]   i_cfg_edge,
    input  logic [N-1:0]   i_mask,
    output logic           o_req,
    output logic [IDW-1:0] o_id,
    input  logic           i_ack,
    output logic [N-1:0]   o_pending
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] id_nxt;
    logic [IDW-1:0] winner;

    logic [N-1:0]   meta;
    logic [N-1:0]   sync_q;
    logic [N-1:0]   sync_d;
    logic [N-1:0]   pending;
    logic [N-1:0]   pending_nxt;
    logic [N-1:0]   eligible;
    logic           ack_fire;

    // Plain two-rank synchroniser followed by the edge-detect delay flop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta   <= '0;
            sync_q <= '0;
            sync_d <= '0;
        end else begin
            meta   <= i_irq;
            sync_q <= meta;
            sync_d <= sync_q;
        end
    end

    assign ack_fire = (state == S_REQ) && i_ack;

    // The set is applied after the clear, so a new edge that lands in the
    // same cycle as the ack of that line keeps the line pending.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < N; i++) begin
            if (i_cfg_edge[i]) begin
                if (ack_fire && (o_id == IDW'(i))) begin
                    pending_nxt[i] = 1'b0;
                end
                if (sync_q[i] && !sync_d[i]) begin
                    pending_nxt[i] = 1'b1;
                end
            end else begin
                pending_nxt[i] = sync_q[i];
            end
        end
    end

    assign eligible = pending & ~i_mask;

`ifdef ZAP_IRQ_RR_EN
    logic [IDW-1:0] rr_ptr;
    logic           hi_found;
    logic [IDW-1:0] hi_win;
    logic [IDW-1:0] lo_win;

    // Two-pass search: the lowest eligible index at or above the pointer wins.
    // If there is none, the lowest eligible index below the pointer wins,
    // which is the wrap from N-1 to 0.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                if (k >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_win   = IDW'(k);
                end else begin
                    lo_win   = IDW'(k);
                end
            end
        end
        winner = hi_found ? hi_win : lo_win;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr <= '0;
        end else if (ack_fire) begin
            rr_ptr <= (o_id == IDW'(N - 1)) ? '0 : o_id + IDW'(1);
        end
    end
`else
    // Descending scan, so the last hit, which is the lowest index, wins.
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = IDW'(k);
            end
        end
    end
`endif

    // Once a grant is issued it is never withdrawn. Masking or a dropped
    // level does not matter until the core acks.
    always_comb begin
        state_nxt = state;
        id_nxt    = o_id;
        case (state)
            S_IDLE: begin
                if (|eligible) begin
                    state_nxt = S_REQ;
                    id_nxt    = winner;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            o_req   <= 1'b0;
            o_id    <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            o_req   <= (state_nxt == S_REQ);
            o_id    <= id_nxt;
            pending <= pending_nxt;
        end
    end

    assign o_pending = pending;

endmodule

// File: tb/tb_zap_irq_sync_arbiter.sv
module tb_zap_irq_sync_arbiter;

    localparam int N   = 8;
    localparam int IDW = $clog2(N);

    logic           i_clk      = 1'b0;
    logic           i_reset_n  = 1'b0;
    logic [N-1:0]   i_irq      = '0;
    logic [N-1:0]   i_cfg_edge = '0;
    logic [N-1:0]   i_mask     = '0;
    logic           i_ack      = 1'b0;
    logic           o_req;
    logic [IDW-1:0] o_id;
    logic [N-1:0]   o_pending;

    int n_cmp = 0;
    int n_bad = 0;

    zap_irq_sync_arbiter #(.N(N)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_irq      (i_irq),
        .i_cfg_edge (i_cfg_edge),
        .i_mask     (i_mask),
        .o_req      (o_req),
        .o_id       (o_id),
        .i_ack      (i_ack),
        .o_pending  (o_pending)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Reference model. It keeps the last three input samples, because a
    // line's value reaches pending two samples late. Pending lines are
    // arbitrated by scanning from a start index with modulo wrap.
    // ------------------------------------------------------------------
    logic [N-1:0] h1 = '0;   // sample taken one edge ago
    logic [N-1:0] h2 = '0;   // two edges ago  (what pending sees now)
    logic [N-1:0] h3 = '0;   // three edges ago (previous value for edge detect)
    logic [N-1:0] m_pend = '0;
    logic         m_req  = 1'b0;
    int           m_id   = 0;
    int           m_ptr  = 0;
    logic [N-1:0] m_np;
    logic [N-1:0] m_elig;
    logic         m_ackd;

    function automatic int pick(input logic [N-1:0] elig, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (elig[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_pend = '0; m_req = 1'b0; m_id = 0; m_ptr = 0;
        end else begin
            m_ackd = m_req && i_ack;
            for (int i = 0; i < N; i++) begin
                if (i_cfg_edge[i])
                    m_np[i] = (h2[i] && !h3[i]) || (m_pend[i] && !(m_ackd && m_id == i));
                else
                    m_np[i] = h2[i];
            end
            m_elig = m_pend & ~i_mask;
            if (!m_req) begin
                if (m_elig != '0) begin
                    m_req = 1'b1;
                    m_id  = pick(m_elig, m_ptr);
                end
            end else if (i_ack) begin
                m_req = 1'b0;
`ifdef ZAP_IRQ_RR_EN
                m_ptr = (m_id + 1) % N;
`endif
            end
            m_pend = m_np;
            h3 = h2; h2 = h1; h1 = i_irq;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            n_cmp++;
            if (o_pending !== m_pend) begin
                n_bad++;
                $display("FAIL model_pending t=%0t actual=%b required=%b", $time, o_pending, m_pend);
            end
            n_cmp++;
            if (o_req !== m_req) begin
                n_bad++;
                $display("FAIL model_req t=%0t actual=%b required=%b", $time, o_req, m_req);
            end
            if (m_req) begin
                n_cmp++;
                if (o_id !== IDW'(m_id)) begin
                    n_bad++;
                    $display("FAIL model_id t=%0t actual=%0d required=%0d", $time, o_id, m_id);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset_n  = 1'b0;
        i_irq      = '0;
        i_mask     = '0;
        i_cfg_edge = '0;
        i_ack      = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        summary();
        $finish;
    end

    int exp_seq[$];
    int waited;

    initial begin
        @(negedge i_clk);
        do_reset();
        chk("reset_req", int'(o_req), 0);
        chk("reset_id", int'(o_id), 0);
        chk("reset_pending", int'(o_pending), 0);

        // Edge latency on line 3
        i_cfg_edge[3] = 1'b1;
        i_irq[3] = 1'b1;
        tick();                          // E0
        i_irq = '0;
        tick();                          // E1
        chk("lat_pend_e1", int'(o_pending[3]), 0);
        tick();                          // E2
        chk("lat_pend_e2", int'(o_pending[3]), 1);
        chk("lat_req_e2", int'(o_req), 0);
        tick();                          // E3
        chk("lat_req_e3", int'(o_req), 1);
        chk("lat_id_e3", int'(o_id), 3);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        chk("lat_req_after_ack", int'(o_req), 0);
        chk("lat_pend_after_ack", int'(o_pending[3]), 0);

        // Fixed priority: 2 before 5, one idle cycle between
        do_reset();
        i_cfg_edge = 8'b0010_0100;
        i_irq      = 8'b0010_0100;
        tick();
        i_irq = '0;
        tick(); tick(); tick();
        chk("prio_req_first", int'(o_req), 1);
        chk("prio_id_first", int'(o_id), 2);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        chk("prio_idle_gap", int'(o_req), 0);
        chk("prio_pend5_kept", int'(o_pending[5]), 1);
        tick();
        chk("prio_req_second", int'(o_req), 1);
        chk("prio_id_second", int'(o_id), 5);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;

        // Level mode, no withdrawal
        do_reset();
        i_irq[1] = 1'b1;
        tick(); tick(); tick(); tick();
        chk("lvl_req", int'(o_req), 1);
        chk("lvl_id", int'(o_id), 1);
        i_irq[1]  = 1'b0;
        i_mask[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("lvl_hold_req", int'(o_req), 1);
            chk("lvl_hold_id", int'(o_id), 1);
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("lvl_no_rereq", int'(o_req), 0);
            tick();
        end

        // Set wins over ack clear on line 4
        do_reset();
        i_cfg_edge[4] = 1'b1;
        i_irq[4] = 1'b1;
        tick();                          // E0
        i_irq = '0;
        tick();                          // E1
        i_irq[4] = 1'b1;
        tick();                          // E2
        i_irq = '0;
        tick();                          // E3
        chk("setwin_req", int'(o_req), 1);
        chk("setwin_id", int'(o_id), 4);
        i_ack = 1'b1;
        tick();                          // E4: ack and new edge together
        i_ack = 1'b0;
        chk("setwin_req_drop", int'(o_req), 0);
        chk("setwin_pend_kept", int'(o_pending[4]), 1);
        tick();
        chk("setwin_rereq", int'(o_req), 1);
        chk("setwin_reid", int'(o_id), 4);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;

        // Arbitration order with lines 0, 1, 7 held in level mode
        do_reset();
`ifdef ZAP_IRQ_RR_EN
        exp_seq = '{0, 1, 7, 0, 1};
`else
        exp_seq = '{0, 0, 0};
`endif
        i_irq = 8'b1000_0011;
        foreach (exp_seq[g]) begin
            waited = 0;
            while (!o_req && waited < 12) begin
                tick();
                waited++;
            end
            if (!o_req) begin
                chk("arb_timeout", 0, 1);
                break;
            end
            chk($sformatf("arb_grant_%0d", g), int'(o_id), exp_seq[g]);
            i_ack = 1'b1;
            tick();
            i_ack = 1'b0;
        end
        i_irq = '0;

        // Async reset mid-handshake
        do_reset();
        i_cfg_edge = 8'b0100_0100;
        i_irq      = 8'b0100_0000;
        tick();
        i_irq = 8'b0000_0100;
        tick();
        i_irq = '0;
        tick(); tick();
        chk("arst_req_before", int'(o_req), 1);
        chk("arst_id_before", int'(o_id), 6);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_req", int'(o_req), 0);
        chk("arst_id", int'(o_id), 0);
        chk("arst_pending", int'(o_pending), 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_irq[6] = 1'b1;
        tick();                          // E0
        i_irq = '0;
        tick(); tick();                  // E1, E2
        chk("arst_relat_e2", int'(o_req), 0);
        tick();                          // E3
        chk("arst_relat_e3", int'(o_req), 1);
        chk("arst_relat_id", int'(o_id), 6);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;

        // Randomised traffic checked by the model
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            i_cfg_edge = N'($urandom);
            for (int c = 0; c < 250; c++) begin
                i_irq = N'($urandom & $urandom);
                if ($urandom_range(0, 9) == 0) i_mask = N'($urandom);
                i_ack = ($urandom_range(0, 2) == 0);
                if (blk == 4 && c == 100) begin
                    #3;
                    i_reset_n = 1'b0;
                    #1;
                    chk("rand_arst_req", int'(o_req), 0);
                    @(negedge i_clk);
                    i_reset_n = 1'b1;
                end
                tick();
            end
        end
        i_ack = 1'b0;
        i_irq = '0;
        tick();

        summary();
        $finish;
    end

endmodule
